gate_bist_checker: RTL and testbench

//  Synthesizable built-in self-test for the two-input gate library (And, Or, Not, Nor, Xor).

---
 rtl/gate_bist_pkg.sv | 21 ++
 rtl/gate_golden_model.sv | 19 +
 rtl/gate_bist_checker.sv | 120 ++++++++++++
 tb/tb_gate_bist_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-library built-in self-test.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit positions of each gate within expected/observed/mask vectors
    localparam int AND_B = 0;
    localparam int OR_B  = 1;
    localparam int NOT_B = 2;
    localparam int NOR_B = 3;
    localparam int XOR_B = 4;

    localparam int NUM_GATES = 5;
    localparam int NUM_VEC   = 4;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the gate library: (a,b) to the expected 5-bit result vector.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    always_comb begin
        expected        = '0;
        expected[AND_B] = a & b;
        expected[OR_B]  = a | b;
        expected[NOT_B] = ~a;
        expected[NOR_B] = ~(a | b);
        expected[XOR_B] = a ^ b;
    end

endmodule

// File: rtl/gate_bist_checker.sv
// Truth-table sweep over the gate library: drives {a,b}, waits a settle time,
// then compares the five gate outputs against the golden model and records results.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_out,
    input  logic       or_out,
    input  logic       not_out,
    input  logic       nor_out,
    input  logic       xor_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic [4:0] first_fail_mask
);

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

    state_t                 state, state_next;
    logic [1:0]             vec;
    logic [3:0]             cnt;
    logic [NUM_GATES-1:0]   expected, observed, mask;
    logic                   start_accept, has_err;

    // The stimulus registers are the vector index itself, so a/b hold 11 in DONE.
    assign a = vec[1];
    assign b = vec[0];

    gate_golden_model u_golden (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    // Case-inequality so that X/Z on an observed output is reported as a mismatch.
    always_comb begin
        observed        = '0;
        observed[AND_B] = and_out;
        observed[OR_B]  = or_out;
        observed[NOT_B] = not_out;
        observed[NOR_B] = nor_out;
        observed[XOR_B] = xor_out;
        mask            = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            mask[i] = (observed[i] !== expected[i]);
        end
        has_err = |mask;
    end

    assign start_accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = SETTLE;
            SETTLE:     if (cnt == LAST_CNT) state_next = CHECK;
            CHECK:      state_next = (vec == LAST_VEC) ? DONE : SETTLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else if (start_accept) begin
            vec             <= '0;
            cnt             <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else if (state == SETTLE) begin
            cnt <= cnt + 4'd1;
        end else if (state == CHECK) begin
            if (has_err) begin
                err_count <= err_count + 3'd1;
                if (err_count == 3'd0) begin
                    first_fail_vec  <= vec;
                    first_fail_mask <= mask;
                end
            end
            if (vec != LAST_VEC) begin
                vec <= vec + 2'd1;
                cnt <= '0;
            end else begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == 3'd0) && !has_err;
            end
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: behavioural gates with injectable faults feed the checker.
module tb_gate_bist_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start2;
    logic       fault_and, fault_xor;

    logic       a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;
    logic [4:0] first_fail_mask;

    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err_count2;
    logic [1:0] first_fail_vec2;
    logic [4:0] first_fail_mask2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_bist_checker #(.SETTLE_CYCLES(2)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .a               (a),
        .b               (b),
        .and_out         (fault_and ? 1'b0 : (a & b)),
        .or_out          (a | b),
        .not_out         (~a),
        .nor_out         (~(a | b)),
        .xor_out         (fault_xor ? ~(a ^ b) : (a ^ b)),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_vec  (first_fail_vec),
        .first_fail_mask (first_fail_mask)
    );

    gate_bist_checker #(.SETTLE_CYCLES(1)) u_dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start2),
        .a               (a2),
        .b               (b2),
        .and_out         (a2 & b2),
        .or_out          (a2 | b2),
        .not_out         (~a2),
        .nor_out         (~(a2 | b2)),
        .xor_out         (a2 ^ b2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .err_count       (err_count2),
        .first_fail_vec  (first_fail_vec2),
        .first_fail_mask (first_fail_mask2)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge, then counts busy cycles until done; optionally re-pulses start mid-run.
    task automatic run_sweep(input bit use_dut2, input int repulse_at, output int busy_n);
        int guard;
        busy_n = 0;
        guard  = 0;
        @(negedge clk);
        if (use_dut2) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        check("accept_busy", use_dut2 ? busy2 : busy, 1);
        check("accept_done_clr", use_dut2 ? done2 : done, 0);
        check("accept_err_clr", use_dut2 ? err_count2 : err_count, 0);
        while (guard < 100) begin
            start = (busy_n == repulse_at) && !use_dut2;
            if (use_dut2 ? busy2 : busy) busy_n++;
            if (use_dut2 ? done2 : done) break;
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        check("sweep_timeout", guard < 100, 1);
    endtask

    initial begin
        int n;
        int guard;
        rst_n     = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        fault_and = 1'b0;
        fault_xor = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", first_fail_vec, 0);
        check("rst_ffm", first_fail_mask, 0);
        rst_n = 1'b1;

        $display("[TB] test 1: correct gates");
        run_sweep(1'b0, -1, n);
        check("t1_busy_len", n, 12);
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_ffm", first_fail_mask, 0);
        check("t1_ab_hold", {a, b}, 2'b11);

        $display("[TB] test 2: and tied low");
        fault_and = 1'b1;
        run_sweep(1'b0, -1, n);
        check("t2_busy_len", n, 12);
        check("t2_err", err_count, 1);
        check("t2_pass", pass, 0);
        check("t2_ffv", first_fail_vec, 2'b11);
        check("t2_ffm", first_fail_mask, 5'b00001);
        fault_and = 1'b0;

        $display("[TB] test 3: inverted xor");
        fault_xor = 1'b1;
        run_sweep(1'b0, -1, n);
        check("t3_err", err_count, 4);
        check("t3_pass", pass, 0);
        check("t3_ffv", first_fail_vec, 2'b00);
        check("t3_ffm", first_fail_mask, 5'b10000);

        $display("[TB] test 5: restart from failed DONE, start re-pulsed while busy");
        fault_xor = 1'b0;
        run_sweep(1'b0, 5, n);
        check("t5_busy_len", n, 12);
        check("t5_pass", pass, 1);
        check("t5_err", err_count, 0);
        check("t5_ffv", first_fail_vec, 0);
        check("t5_ffm", first_fail_mask, 0);

        $display("[TB] test 4: reset mid-sweep at vec=2");
        fault_xor = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(a == 1'b1 && b == 1'b0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t4_reach_vec2", guard < 50, 1);
        check("t4_err_before", err_count, 2);
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy, 0);
        check("t4_ab", {a, b}, 2'b00);
        check("t4_err", err_count, 0);
        check("t4_ffm", first_fail_mask, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        fault_xor = 1'b0;
        run_sweep(1'b0, -1, n);
        check("t4_busy_len", n, 12);
        check("t4_pass", pass, 1);
        check("t4_err_after", err_count, 0);

        $display("[TB] test 6: SETTLE_CYCLES=1");
        run_sweep(1'b1, -1, n);
        check("t6_busy_len", n, 8);
        check("t6_done", done2, 1);
        check("t6_pass", pass2, 1);
        check("t6_err", err_count2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
